// File: rtl/uart_multi_ch_sender.sv
// Multi-channel ASCII frame sender: round-robin over NUM_CH triggered channels,
// sequential double-dabble conversion, "<TAG><digits>[,HH]CR LF" to a UART TX core.
// Optional checksum bytes are built in when SENDER_CSUM_EN is defined.
module uart_multi_ch_sender #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int LZ_BLANK = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        i_trig,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH*8-1:0]      i_tag,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     o_busy,
  output logic [NUM_CH-1:0]        o_overrun
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = DIGITS * 4;
  localparam int SW = $clog2(DATA_W + 1);
`ifdef SENDER_CSUM_EN
  localparam int FL = DIGITS + 6;
`else
  localparam int FL = DIGITS + 3;
`endif
  localparam int IW = $clog2(FL);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  if (pow10(DIGITS) <= (64'd1 << DATA_W)) begin : g_bad_digits
    $error("DIGITS too small: 10^DIGITS must exceed 2^DATA_W");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_WAIT} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CH-1:0]              pend_q, pend_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  snap_q, snap_d;
  logic [CW-1:0]                  ptr_q, ptr_d;
  logic [DATA_W-1:0]              bin_q, bin_d;
  logic [BW-1:0]                  bcd_q, bcd_d;
  logic [7:0]                     tag_q, tag_d;
  logic [SW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           tx_start_q, tx_start_d;
  logic [7:0]                     tx_data_q, tx_data_d;
  logic [NUM_CH-1:0]              ovr_q, ovr_d;

  logic                           gnt_vld, grab;
  logic [CW-1:0]                  gnt_ch;
  logic [DIGITS-1:0][7:0]         dig_b;
  logic [7:0]                     byte_sel;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [BW+DATA_W-1:0] dd_step(input logic [BW-1:0] b,
                                                   input logic [DATA_W-1:0] v);
    logic [BW-1:0] t;
    t = b;
    for (int d = 0; d < DIGITS; d++)
      if (t[d*4 +: 4] >= 4'd5) t[d*4 +: 4] = t[d*4 +: 4] + 4'd3;
    return {t, v} << 1;
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Round-robin search starting one past the last-served channel.
  always_comb begin
    int c;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    c       = 0;
    for (int o = 1; o <= NUM_CH; o++) begin
      c = (int'(ptr_q) + o) % NUM_CH;
      if (!gnt_vld && pend_q[c]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(c);
      end
    end
  end

  assign grab = (state_q == S_IDLE) && gnt_vld && !tx_busy;

  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[(DIGITS-1-i)*4 +: 4] != 4'd0) lead = 1'b0;
      dig_b[i] = (LZ_BLANK != 0 && lead && i != DIGITS-1) ? 8'h20
                 : {4'h3, bcd_q[(DIGITS-1-i)*4 +: 4]};
    end
  end

  // In S_WAIT the byte being prepared is the one after the current index.
  always_comb begin
    int sel;
`ifdef SENDER_CSUM_EN
    logic [7:0] csum;
    csum = tag_q;
    for (int i = 0; i < DIGITS; i++) csum = csum ^ dig_b[i];
`endif
    sel      = (state_q == S_WAIT) ? int'(idx_q) + 1 : int'(idx_q);
    byte_sel = 8'h0A;
    if (sel == FL - 2) byte_sel = 8'h0D;
`ifdef SENDER_CSUM_EN
    if (sel == DIGITS + 1) byte_sel = 8'h2C;
    if (sel == DIGITS + 2) byte_sel = hex_ch(csum[7:4]);
    if (sel == DIGITS + 3) byte_sel = hex_ch(csum[3:0]);
`endif
    for (int i = 0; i < DIGITS; i++)
      if (sel == i + 1) byte_sel = dig_b[i];
    if (sel == 0) byte_sel = tag_q;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    ptr_d      = ptr_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ovr_d      = '0;

    if (grab) pend_d[gnt_ch] = 1'b0;
    // A same-cycle trigger beats the arbiter's clear and is not an overrun.
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_trig[k]) begin
        pend_d[k] = 1'b1;
        snap_d[k] = i_data[k*DATA_W +: DATA_W];
        ovr_d[k]  = pend_q[k] && !(grab && int'(gnt_ch) == k);
      end
    end

    case (state_q)
      S_IDLE: if (grab) begin
        ptr_d   = gnt_ch;
        bin_d   = snap_q[gnt_ch];
        bcd_d   = '0;
        tag_d   = i_tag[int'(gnt_ch)*8 +: 8];
        cnt_d   = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(DATA_W - 1)) begin
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = byte_sel;
        state_d    = S_WAIT;
      end
      S_WAIT: if (tx_done) begin
        if (idx_q == IW'(FL - 1)) begin
          state_d = S_IDLE;
        end else begin
          // Next byte is launched straight from here so tx_start follows tx_done by one cycle.
          idx_d      = idx_q + 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      snap_q     <= '0;
      ptr_q      <= CW'(NUM_CH - 1);
      bin_q      <= '0;
      bcd_q      <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      ptr_q      <= ptr_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_uart_multi_ch_sender.sv
// Directed bench for uart_multi_ch_sender: table of frame vectors plus
// hand sequences for latency, flow control, overrun and mid-frame reset.
module tb_uart_multi_ch_sender;

`ifdef SENDER_CSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 6;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  i_trig, trig_z;
  logic [15:0] i_data;
  logic [15:0] i_tag;
  logic        tx_busy, tx_done, tx_start, o_busy;
  logic [7:0]  tx_data;
  logic [1:0]  o_overrun;
  logic        tx_busy_z, tx_done_z, tx_start_z, o_busy_z;
  logic [7:0]  tx_data_z;
  logic [1:0]  o_overrun_z;
  logic        force_busy = 1'b0;

  uart_multi_ch_sender #(.NUM_CH(2), .DATA_W(8), .DIGITS(3), .LZ_BLANK(1)) u_dut (
    .clk(clk), .reset(reset), .i_trig(i_trig), .i_data(i_data), .i_tag(i_tag),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .o_busy(o_busy), .o_overrun(o_overrun));

  uart_multi_ch_sender #(.NUM_CH(2), .DATA_W(8), .DIGITS(3), .LZ_BLANK(0)) u_dut_z (
    .clk(clk), .reset(reset), .i_trig(trig_z), .i_data(i_data), .i_tag(i_tag),
    .tx_busy(tx_busy_z), .tx_done(tx_done_z), .tx_start(tx_start_z), .tx_data(tx_data_z),
    .o_busy(o_busy_z), .o_overrun(o_overrun_z));

  // UART model: tx_done pulses 10 cycles after tx_start.
  int cnt = 0, cnt_z = 0, cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) cnt <= 10; else if (cnt > 0) cnt <= cnt - 1;
    if (tx_start_z) cnt_z <= 10; else if (cnt_z > 0) cnt_z <= cnt_z - 1;
  end
  assign tx_done   = (cnt == 1);
  assign tx_busy   = (cnt > 1) || force_busy;
  assign tx_done_z = (cnt_z == 1);
  assign tx_busy_z = (cnt_z > 1);

  logic [7:0] rx_q[$], rxz_q[$];
  int         st_q[$];
  int         ov0 = 0, ov1 = 0;
  always @(negedge clk) begin
    if (tx_start) begin rx_q.push_back(tx_data); st_q.push_back(cyc); end
    if (tx_start_z) rxz_q.push_back(tx_data_z);
    if (o_overrun[0]) ov0++;
    if (o_overrun[1]) ov1++;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
  endfunction

  // Reference frame built with plain integer division.
  function automatic logic [7:0] exp_byte(input logic [7:0] tag, input int v, input bit lz, input int idx);
    logic [7:0] b [4];
    int d0, d1, d2, x;
    d0 = v / 100; d1 = (v / 10) % 10; d2 = v % 10;
    b[0] = tag;
    b[1] = (lz && d0 == 0) ? 8'h20 : 8'(8'h30 + d0);
    b[2] = (lz && d0 == 0 && d1 == 0) ? 8'h20 : 8'(8'h30 + d1);
    b[3] = 8'(8'h30 + d2);
    x = int'(b[0] ^ b[1] ^ b[2] ^ b[3]);
    if (idx <= 3) return b[idx];
`ifdef SENDER_CSUM_EN
    if (idx == 4) return 8'h2C;
    if (idx == 5) return hexc(x / 16);
    if (idx == 6) return hexc(x % 16);
`endif
    return (idx == FL - 2) ? 8'h0D : 8'h0A;
  endfunction

  task automatic check_frame(input string nm, input logic [7:0] tag, input int v,
                             input bit lz, input int base, input bit z);
    logic [7:0] act;
    for (int i = 0; i < FL; i++) begin
      if (z) act = (base + i < rxz_q.size()) ? rxz_q[base+i] : 8'hxx;
      else   act = (base + i < rx_q.size())  ? rx_q[base+i]  : 8'hxx;
      chk($sformatf("%s_b%0d", nm, i), int'(act), int'(exp_byte(tag, v, lz, i)));
    end
  endtask

  task automatic wait_bytes(input string nm, input int n, input int budget, input bit z);
    int b;
    b = 0;
    while (((z ? rxz_q.size() : rx_q.size()) < n) && b < budget) begin
      @(negedge clk); b++;
    end
    chk({nm, "_timeout"}, (b < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int b;
    b = 0;
    while (o_busy && b < 400) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
    chk({nm, "_idle"}, int'(o_busy), 0);
  endtask

  task automatic pulse(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    i_data = {d1, d0};
    i_trig = m;
    @(negedge clk);
    i_trig = 2'b00;
  endtask

  typedef struct {
    logic [1:0] trig;
    logic [7:0] d0, d1;
    int         nfr;
    int         c0, v0, c1, v1;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] tags[2];
  logic [7:0] lit[FL];

  initial begin
    int base, t0, n, b, ov0s, ov1s;
    tags[0] = 8'h44; tags[1] = 8'h54;
    i_tag = {8'h54, 8'h44};
`ifdef SENDER_CSUM_EN
    lit = '{8'h44, 8'h20, 8'h20, 8'h37, 8'h2C, 8'h37, 8'h33, 8'h0D, 8'h0A};
`else
    lit = '{8'h44, 8'h20, 8'h20, 8'h37, 8'h0D, 8'h0A};
`endif
    vecs[0] = '{2'b01, 8'd255, 8'd0,   1, 0, 255, 0, 0};
    vecs[1] = '{2'b01, 8'd100, 8'd0,   1, 0, 100, 0, 0};
    vecs[2] = '{2'b01, 8'd0,   8'd0,   1, 0, 0,   0, 0};
    vecs[3] = '{2'b11, 8'd12,  8'd200, 2, 1, 200, 0, 12};
    vecs[4] = '{2'b10, 8'd0,   8'd9,   1, 1, 9,   0, 0};
    vecs[5] = '{2'b11, 8'd1,   8'd2,   2, 0, 1,   1, 2};

    reset = 1'b1; i_trig = '0; trig_z = '0; i_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    reset = 1'b0;

    // First frame: literal bytes and trigger-to-tx_start latency.
    pulse(2'b01, 8'd7, 8'd0);
    t0 = cyc;
    wait_bytes("lat", FL, 300, 1'b0);
    chk("latency", st_q[0] - t0, 10);
    for (int i = 0; i < FL; i++) chk($sformatf("lit7_b%0d", i), int'(rx_q[i]), int'(lit[i]));
    wait_idle("lit7");

    for (int k = 0; k < 6; k++) begin
      base = rx_q.size();
      pulse(vecs[k].trig, vecs[k].d0, vecs[k].d1);
      wait_bytes($sformatf("vec%0d", k), base + vecs[k].nfr * FL, 600, 1'b0);
      check_frame($sformatf("vec%0d_f0", k), tags[vecs[k].c0], vecs[k].v0, 1'b1, base, 1'b0);
      if (vecs[k].nfr > 1)
        check_frame($sformatf("vec%0d_f1", k), tags[vecs[k].c1], vecs[k].v1, 1'b1, base + FL, 1'b0);
      wait_idle($sformatf("vec%0d", k));
    end

    // tx_busy held high: request stays queued, FSM stays idle.
    force_busy = 1'b1;
    base = rx_q.size();
    pulse(2'b01, 8'd3, 8'd0);
    repeat (50) @(negedge clk);
    chk("busy_hold_bytes", rx_q.size(), base);
    chk("busy_hold_idle", int'(o_busy), 0);
    force_busy = 1'b0;
    wait_bytes("busy_rel", base + FL, 300, 1'b0);
    check_frame("busy_rel", 8'h44, 3, 1'b1, base, 1'b0);
    wait_idle("busy_rel");

    // Overrun on ch1 during a ch0 frame; ch0 re-trigger during its own frame.
    ov0s = ov0; ov1s = ov1;
    base = rx_q.size();
    pulse(2'b01, 8'd5, 8'd0);
    wait_bytes("ovr_start", base + 1, 300, 1'b0);
    pulse(2'b10, 8'd0, 8'd42);
    pulse(2'b10, 8'd0, 8'd43);
    pulse(2'b01, 8'd6, 8'd0);
    wait_bytes("ovr", base + 3 * FL, 1200, 1'b0);
    check_frame("ovr_d5", 8'h44, 5, 1'b1, base, 1'b0);
    check_frame("ovr_t43", 8'h54, 43, 1'b1, base + FL, 1'b0);
    check_frame("ovr_d6", 8'h44, 6, 1'b1, base + 2 * FL, 1'b0);
    chk("ovr1_pulses", ov1 - ov1s, 1);
    chk("ovr0_pulses", ov0 - ov0s, 0);
    wait_idle("ovr");

    // Reset in the cycle of the second tx_done aborts the frame and drops pending ch1.
    base = rx_q.size();
    pulse(2'b01, 8'd77, 8'd0);
    pulse(2'b10, 8'd0, 8'd9);
    n = 0; b = 0;
    while (n < 2 && b < 400) begin
      @(negedge clk); b++;
      if (tx_done) n++;
    end
    chk("rst_mid_reach", n, 2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_bytes", rx_q.size(), base + 2);
    chk("rst_mid_b0", int'(rx_q[base]), 8'h44);
    chk("rst_mid_b1", int'(rx_q[base+1]), 8'h20);
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_start", int'(tx_start), 0);

    base = rx_q.size();
    pulse(2'b01, 8'd123, 8'd0);
    wait_bytes("post_rst", base + FL, 300, 1'b0);
    check_frame("post_rst", 8'h44, 123, 1'b1, base, 1'b0);

    // Zero-padded instance.
    @(negedge clk);
    i_data = 16'h0005;
    trig_z = 2'b01;
    @(negedge clk);
    trig_z = 2'b00;
    wait_bytes("lz0", FL, 300, 1'b1);
    check_frame("lz0_d005", 8'h44, 5, 1'b0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
